leitor_na: RTL
==============

LEITOR_NA -- requirements
Module: leitor_na

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one node cost.
REQ-002 SHALL have parameter NUM_COMPARADOR, default 8, costs per output batch.
REQ-003 SHALL have parameter ADDR_WIDTH, default 6, node-memory address width (depth 2^ADDR_WIDTH).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port iniciar_in  input  1  start-scan pulse.
REQ-007 SHALL have port num_nos_in  input  ADDR_WIDTH+1  node count to scan, sampled at start.
REQ-008 SHALL have port mem_rd_en_out  output  1  node-memory read enable.
REQ-009 SHALL have port mem_addr_out  output  ADDR_WIDTH  node-memory read address.
REQ-010 SHALL have port mem_data_in  input  DATA_WIDTH  node cost, valid 1 cycle after read.
REQ-011 SHALL have port mem_aberto_in  input  1  node-open flag, same timing as mem_data_in.
REQ-012 SHALL have port iniciar_out  output  1  minimum-comparator clear pulse.
REQ-013 SHALL have port atualizar_out  output  1  batch-valid pulse.
REQ-014 SHALL have port data_out  output  DATA_WIDTH*NUM_COMPARADOR  packed batch, slot i at bits [DATA_WIDTH*i+DATA_WIDTH-1:DATA_WIDTH*i].
REQ-015 SHALL have port ocupado_out  output  1  scan in progress.
REQ-016 SHALL have port pronto_out  output  1  scan-complete pulse, downstream minimum valid.

Function
REQ-017 SHALL implement FSM OCIOSO -> INICIAR -> LER -> FIM -> OCIOSO; all outputs registered.
REQ-018 SHALL leave OCIOSO only when iniciar_in=1; iniciar_in outside OCIOSO ignored.
REQ-019 SHALL latch N=min(num_nos_in, 2^ADDR_WIDTH) on the start edge.
REQ-020 SHALL, start sampled at cycle 0, hold iniciar_out=1 for exactly cycle 1; ocupado_out=1 from cycle 1 until the pronto_out cycle, inclusive.
REQ-021 SHALL in LER assert mem_rd_en_out with mem_addr_out=k during cycle 2+k, k=0..N-1, consecutive, no gaps.
REQ-022 SHALL capture read k at the end of cycle 3+k into fill slot k mod NUM_COMPARADOR; capture mem_data_in if mem_aberto_in=1, else all-ones.
REQ-023 SHALL, when slot NUM_COMPARADOR-1 or node N-1 is captured, present that batch on data_out with atualizar_out=1 for exactly one cycle (cycle 4+k); unfilled slots all-ones.
REQ-024 SHALL drive data_out all-ones whenever atualizar_out=0.
REQ-025 SHALL enter FIM after final capture; pronto_out=1 for one cycle at N+4 (N>=1).
REQ-026 SHALL, for N=0, issue no reads and no atualizar_out; pronto_out=1 at cycle 2.
REQ-027 SHALL accept a new iniciar_in in the cycle after pronto_out.
REQ-028 SHALL keep mem_addr_out at 0 when mem_rd_en_out=0.

Reset
REQ-029 SHALL, on rst=1 at any time including mid-scan, immediately force state OCIOSO, fill buffer cleared, all 1-bit outputs 0, mem_addr_out 0, data_out all-ones.
REQ-030 SHALL resume only on a new iniciar_in after rst deasserts; no partial batch emitted.

Verification
REQ-031 SHALL cover: N=8, costs 10..17 all open -> iniciar_out cycle 1, reads cycles 2-9, atualizar_out cycle 11 with slots 0..7=10..17, pronto_out cycle 12.
REQ-032 SHALL cover: N=11, node 9 closed cost 3, node 10 open cost 5 -> second atualizar_out cycle 14, slot 0=mem[8], slot 1=FF, slot 2=5, slots 3-7=FF; pronto_out cycle 15.
REQ-033 SHALL cover: N=0 -> iniciar_out cycle 1, pronto_out cycle 2, mem_rd_en_out never 1.
REQ-034 SHALL cover: num_nos_in=100 -> clamped to 64, 8 atualizar_out pulses, last read address 63, pronto_out cycle 68.
REQ-035 SHALL cover: iniciar_in repeated at cycle 5 of a scan -> ignored, timing unchanged; rst=1 at cycle 6 -> outputs reset that cycle, no atualizar_out/pronto_out follow.

Source files
------------

// File: rtl/leitor_na.sv
// leitor_na: node-memory scanner feeding a bank of minimum comparators.
//
// On a start pulse the block latches a node count N (clamped to the memory
// depth), pulses iniciar_out to clear the downstream comparators, then reads
// nodes 0..N-1 back to back. Each returned cost is packed into a batch of
// NUM_COMPARADOR slots. Closed nodes enter the batch as all-ones so that they
// can never win the minimum. A full batch, or the last partial batch, is
// presented for one cycle on data_out with atualizar_out. A final pronto_out
// pulse tells the consumer that the downstream minimum is valid.
//
// Ports:
//   clk, rst        - clock (rising edge) and asynchronous active-high reset
//   iniciar_in      - start-scan pulse, honoured only while idle
//   num_nos_in      - number of nodes to scan, sampled with iniciar_in
//   mem_rd_en_out   - node-memory read enable
//   mem_addr_out    - node-memory read address (0 while not reading)
//   mem_data_in     - node cost, valid one cycle after the read
//   mem_aberto_in   - node-open flag, same timing as mem_data_in
//   iniciar_out     - comparator clear pulse
//   atualizar_out   - batch-valid pulse
//   data_out        - packed batch, slot i at [DATA_WIDTH*i +: DATA_WIDTH]
//   ocupado_out     - scan in progress, through the pronto_out cycle
//   pronto_out      - scan-complete pulse
module leitor_na #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_COMPARADOR = 8,
    parameter int ADDR_WIDTH     = 6
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               iniciar_in,
    input  logic [ADDR_WIDTH:0]                num_nos_in,
    output logic                               mem_rd_en_out,
    output logic [ADDR_WIDTH-1:0]              mem_addr_out,
    input  logic [DATA_WIDTH-1:0]              mem_data_in,
    input  logic                               mem_aberto_in,
    output logic                               iniciar_out,
    output logic                               atualizar_out,
    output logic [DATA_WIDTH*NUM_COMPARADOR-1:0] data_out,
    output logic                               ocupado_out,
    output logic                               pronto_out
);

    localparam int BW = DATA_WIDTH * NUM_COMPARADOR;
    localparam int SW = (NUM_COMPARADOR > 1) ? $clog2(NUM_COMPARADOR) : 1;
    localparam logic [ADDR_WIDTH:0] MAX_NOS  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] UM       = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [SW-1:0]       SLOT_FIM = SW'(NUM_COMPARADOR - 1);

    typedef enum logic [1:0] {
        OCIOSO,
        INICIAR,
        LER,
        FIM
    } estado_t;

    estado_t                estado;
    logic [ADDR_WIDTH:0]    num_nos;
    logic                   pend_valid;
    logic [ADDR_WIDTH-1:0]  pend_idx;
    logic [SW-1:0]          slot;
    logic [BW-1:0]          fill_buf;

    logic [ADDR_WIDTH:0]    ultimo;
    logic                   ultimo_rd;
    logic                   ultima_cap;
    logic                   slot_cheio;
    logic [DATA_WIDTH-1:0]  cap_word;
    logic [BW-1:0]          merged;

    // Capture path: the word arriving this cycle merged into the fill buffer,
    // plus the "last read", "last capture" and "batch full" decisions.
    always_comb begin
        ultimo     = num_nos - UM;
        ultimo_rd  = ({1'b0, mem_addr_out} == ultimo);
        ultima_cap = ({1'b0, pend_idx} == ultimo);
        slot_cheio = (slot == SLOT_FIM);
        cap_word   = mem_aberto_in ? mem_data_in : {DATA_WIDTH{1'b1}};
        merged     = fill_buf;
        merged[int'(slot)*DATA_WIDTH +: DATA_WIDTH] = cap_word;
    end

    // Scan FSM. pend_valid/pend_idx delay the read strobe by one cycle so the
    // capture lines up with the memory's one-cycle read latency. The idle
    // state also ignores a start seen during the pronto_out cycle, so a new
    // scan begins no earlier than the cycle after completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado        <= OCIOSO;
            num_nos       <= '0;
            pend_valid    <= 1'b0;
            pend_idx      <= '0;
            slot          <= '0;
            fill_buf      <= '1;
            mem_rd_en_out <= 1'b0;
            mem_addr_out  <= '0;
            iniciar_out   <= 1'b0;
            atualizar_out <= 1'b0;
            data_out      <= '1;
            ocupado_out   <= 1'b0;
            pronto_out    <= 1'b0;
        end else begin
            iniciar_out   <= 1'b0;
            atualizar_out <= 1'b0;
            data_out      <= '1;
            pronto_out    <= 1'b0;
            pend_valid    <= mem_rd_en_out;
            pend_idx      <= mem_addr_out;
            case (estado)
                OCIOSO: begin
                    ocupado_out <= 1'b0;
                    if (iniciar_in && !pronto_out) begin
                        num_nos     <= (num_nos_in > MAX_NOS) ? MAX_NOS : num_nos_in;
                        iniciar_out <= 1'b1;
                        ocupado_out <= 1'b1;
                        fill_buf    <= '1;
                        slot        <= '0;
                        estado      <= INICIAR;
                    end
                end
                INICIAR: begin
                    if (num_nos == '0) begin
                        pronto_out <= 1'b1;
                        estado     <= OCIOSO;
                    end else begin
                        mem_rd_en_out <= 1'b1;
                        mem_addr_out  <= '0;
                        estado        <= LER;
                    end
                end
                LER: begin
                    if (mem_rd_en_out) begin
                        if (ultimo_rd) begin
                            mem_rd_en_out <= 1'b0;
                            mem_addr_out  <= '0;
                        end else begin
                            mem_addr_out <= mem_addr_out + 1'b1;
                        end
                    end
                    if (pend_valid) begin
                        if (slot_cheio || ultima_cap) begin
                            data_out      <= merged;
                            atualizar_out <= 1'b1;
                            fill_buf      <= '1;
                            slot          <= '0;
                        end else begin
                            fill_buf <= merged;
                            slot     <= slot + 1'b1;
                        end
                        if (ultima_cap) begin
                            estado <= FIM;
                        end
                    end
                end
                FIM: begin
                    pronto_out <= 1'b1;
                    estado     <= OCIOSO;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule
